cp0_unit: RTL and testbench

- Coprocessor 0 for the pipelined MIPS core. It sits directly downstream of the timer blocks and consumes their IRQ lines as HWInt inputs.
- Holds SR, Cause and EPC. Decides on each cycle whether the instruction at the macro-PC (M stage) is preempted by an interrupt or exception.
- Drives the flush/redirect request and EPC to the pipeline control and NPC logic. Services mfc0/mtc0/eret.

---
 rtl/cp0_unit.sv | 114 +++++++++++
 tb/tb_cp0_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC, interrupt/exception request, mfc0/mtc0/eret.
// Optional PRId register (reg 15) enabled by defining CP0_PRID_EN.
module cp0_unit #(
  parameter int          HWINT_W    = 6,
  parameter logic [31:0] PRID_VALUE = 32'h0000_2024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         cp0_addr,
  input  logic               cp0_we,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  input  logic [31:0]        vpc,
  input  logic               bd_in,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic               eret,
  input  logic [HWINT_W-1:0] hwint,
  output logic               req,
  output logic [31:0]        epc_out
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [HWINT_W-1:0] im_r;
  logic               exl_r;
  logic               ie_r;
  logic               bd_r;
  logic [HWINT_W-1:0] ip_r;
  logic [4:0]         exc_code_r;
  logic [31:0]        epc_r;

  logic               int_req_s;
  logic               exc_req_s;
  logic [31:0]        epc_base_s;
  logic [31:0]        epc_next_s;
  logic               wr_sr_s;
  logic               wr_epc_s;

  // Request decision uses live hwint so an interrupt is taken in the cycle it arrives
  always_comb begin
    int_req_s  = (|(hwint & im_r)) & ie_r & ~exl_r;
    exc_req_s  = exc_valid & ~exl_r;
    req        = int_req_s | exc_req_s;
    epc_base_s = bd_in ? (vpc - 32'd4) : vpc;
    epc_next_s = {epc_base_s[31:2], 2'b00};
    wr_sr_s    = cp0_we & (cp0_addr == ADDR_SR);
    wr_epc_s   = cp0_we & (cp0_addr == ADDR_EPC);
  end

  // State update: a taken request overrides any mtc0 or eret in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      im_r       <= '0;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      bd_r       <= 1'b0;
      ip_r       <= '0;
      exc_code_r <= 5'd0;
      epc_r      <= 32'd0;
    end else begin
      ip_r <= hwint;
      if (req) begin
        exl_r      <= 1'b1;
        bd_r       <= bd_in;
        exc_code_r <= int_req_s ? 5'd0 : exc_code;
        epc_r      <= epc_next_s;
      end else begin
        if (wr_sr_s) begin
          im_r <= cp0_wdata[15:10];
          ie_r <= cp0_wdata[0];
        end
        // eret clears EXL after any simultaneous SR write has been applied
        if (eret) begin
          exl_r <= 1'b0;
        end else if (wr_sr_s) begin
          exl_r <= cp0_wdata[1];
        end
        if (wr_epc_s) begin
          epc_r <= cp0_wdata;
        end
      end
    end
  end

  // mfc0 read mux; unmapped registers read zero
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, im_r, 8'd0, exl_r, ie_r};
      ADDR_CAUSE: cp0_rdata = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'd0};
      ADDR_EPC:   cp0_rdata = epc_r;
`ifdef CP0_PRID_EN
      ADDR_PRID:  cp0_rdata = PRID_VALUE;
`else
      ADDR_PRID:  cp0_rdata = 32'd0;
`endif
      default:    cp0_rdata = 32'd0;
    endcase
  end

  // EPC forwarding lets an mtc0 EPC be consumed by an eret in the same cycle
  always_comb begin
    if (wr_epc_s) begin
      epc_out = cp0_wdata;
    end else begin
      epc_out = epc_r;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit with hand-computed expectations.
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret;
  logic [5:0]  hwint;
  logic        req;
  logic [31:0] epc_out;

  int checks;
  int failures;

  cp0_unit dut (
    .clk       (clk),
    .reset     (reset),
    .cp0_addr  (cp0_addr),
    .cp0_we    (cp0_we),
    .cp0_wdata (cp0_wdata),
    .cp0_rdata (cp0_rdata),
    .vpc       (vpc),
    .bd_in     (bd_in),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .eret      (eret),
    .hwint     (hwint),
    .req       (req),
    .epc_out   (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we    = 1'b1;
    cp0_addr  = a;
    cp0_wdata = d;
    step();
    cp0_we    = 1'b0;
  endtask

  initial begin
    logic [31:0] prid_exp;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    cp0_addr  = 5'd0;
    cp0_we    = 1'b0;
    cp0_wdata = 32'd0;
    vpc       = 32'd0;
    bd_in     = 1'b0;
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    eret      = 1'b0;
    hwint     = 6'd0;
    step();
    step();
    reset = 1'b0;

    // reset state
    chk_rd("rst_sr", 5'd12, 32'h0000_0000);
    chk_rd("rst_cause", 5'd13, 32'h0000_0000);
    chk_rd("rst_epc", 5'd14, 32'h0000_0000);
    hwint = 6'h3F;
    #1;
    check("rst_req_ie0", {31'd0, req}, 32'd0);
    check("rst_epc_out", epc_out, 32'd0);
    hwint = 6'h00;
    step();

    // interrupt on timer0 line
    mtc0(5'd12, 32'h0000_0401);
    chk_rd("sr_write", 5'd12, 32'h0000_0401);
    hwint = 6'h01;
    vpc   = 32'h0000_3010;
    bd_in = 1'b0;
    #1;
    check("int_req", {31'd0, req}, 32'd1);
    step();
    check("int_req_held", {31'd0, req}, 32'd0);
    chk_rd("int_sr_exl", 5'd12, 32'h0000_0403);
    chk_rd("int_cause", 5'd13, 32'h0000_0400);
    chk_rd("int_epc", 5'd14, 32'h0000_3010);

    // exception in delay slot with IE cleared
    mtc0(5'd12, 32'h0000_0000);
    hwint     = 6'h00;
    step();
    exc_valid = 1'b1;
    exc_code  = 5'd4;
    vpc       = 32'h0000_3024;
    bd_in     = 1'b1;
    #1;
    check("exc_req", {31'd0, req}, 32'd1);
    step();
    exc_valid = 1'b0;
    bd_in     = 1'b0;
    chk_rd("exc_cause", 5'd13, 32'h8000_0010);
    chk_rd("exc_epc", 5'd14, 32'h0000_3020);

    // interrupt beats simultaneous exception
    mtc0(5'd12, 32'h0000_0801);
    hwint     = 6'h02;
    exc_valid = 1'b1;
    exc_code  = 5'd10;
    vpc       = 32'h0000_3050;
    #1;
    check("prio_req", {31'd0, req}, 32'd1);
    step();
    exc_valid = 1'b0;
    chk_rd("prio_cause", 5'd13, 32'h0000_0800);
    chk_rd("prio_epc", 5'd14, 32'h0000_3050);

    // mtc0 EPC together with eret: forwarded, then pending interrupt re-fires
    cp0_we    = 1'b1;
    cp0_addr  = 5'd14;
    cp0_wdata = 32'h0000_3040;
    eret      = 1'b1;
    #1;
    check("fwd_epc_out", epc_out, 32'h0000_3040);
    check("fwd_req_in_handler", {31'd0, req}, 32'd0);
    step();
    cp0_we = 1'b0;
    eret   = 1'b0;
    #1;
    check("eret_refire_req", {31'd0, req}, 32'd1);
    chk_rd("eret_epc", 5'd14, 32'h0000_3040);
    chk_rd("eret_sr", 5'd12, 32'h0000_0801);
    vpc = 32'h0000_3060;
    step();

    // req with mtc0 SR: the write is lost
    eret = 1'b1;
    step();
    eret      = 1'b0;
    vpc       = 32'h0000_3070;
    cp0_we    = 1'b1;
    cp0_addr  = 5'd12;
    cp0_wdata = 32'h0000_0000;
    #1;
    check("race_req", {31'd0, req}, 32'd1);
    step();
    cp0_we = 1'b0;
    chk_rd("race_sr", 5'd12, 32'h0000_0803);
    chk_rd("race_epc", 5'd14, 32'h0000_3070);
`ifdef CP0_PRID_EN
    prid_exp = 32'h0000_2024;
`else
    prid_exp = 32'h0000_0000;
`endif
    chk_rd("prid", 5'd15, prid_exp);
    chk_rd("unmapped", 5'd3, 32'h0000_0000);

    // Cause is read-only through mtc0
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk_rd("cause_ro", 5'd13, 32'h0000_0800);
    mtc0(5'd15, 32'hFFFF_FFFF);
    chk_rd("prid_ro", 5'd15, prid_exp);

    // vpc-4 wraparound in a delay slot
    hwint = 6'h00;
    mtc0(5'd12, 32'h0000_0000);
    exc_valid = 1'b1;
    exc_code  = 5'd12;
    vpc       = 32'h0000_0000;
    bd_in     = 1'b1;
    step();
    exc_valid = 1'b0;
    bd_in     = 1'b0;
    chk_rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    chk_rd("wrap_cause", 5'd13, 32'h8000_0030);
    chk_rd("wrap_sr", 5'd12, 32'h0000_0002);

    // reset mid-handler clears everything
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_rd("mid_rst_sr", 5'd12, 32'h0000_0000);
    chk_rd("mid_rst_cause", 5'd13, 32'h0000_0000);
    chk_rd("mid_rst_epc", 5'd14, 32'h0000_0000);

    // unaligned vpc: low bits forced to zero
    exc_valid = 1'b1;
    exc_code  = 5'd5;
    vpc       = 32'h0000_3013;
    step();
    exc_valid = 1'b0;
    chk_rd("align_epc", 5'd14, 32'h0000_3010);
    chk_rd("align_cause", 5'd13, 32'h0000_0014);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
